// File: rtl/lector_columnas_teclado.sv
// lector_columnas_teclado
// Column-side reader for a 4x4 matrix keypad. The row scanner (clk_sec domain)
// drives the rows one-hot in a 5-step frame 1111, 1000, 0100, 0010, 0001. This
// block watches the driven row pattern and the column sense lines on the fast
// clock, samples each row once after it has settled, decides per frame whether
// no key, one key or several keys are down, and debounces over whole frames.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          asynchronous active-high reset
//   fila[3:0]    row pattern driven by the scanner (asynchronous to clk)
//   columna[3:0] column sense lines, active-high
//   tecla[3:0]   code (4*row + column) of the last accepted key, held
//   tecla_valida one-cycle pulse on press acceptance
//   tecla_suelta one-cycle pulse on release acceptance
//   presionada   high from press acceptance until release acceptance
//   multi_tecla  high when the last complete frame saw more than one key
module lector_columnas_teclado #(
  parameter int SETTLE     = 4,
  parameter int DEB_FRAMES = 3,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fila,
  input  logic [3:0] columna,
  output logic [3:0] tecla,
  output logic       tecla_valida,
  output logic       tecla_suelta,
  output logic       presionada,
  output logic       multi_tecla
);

  localparam int FW = $clog2(DEB_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} estado_t;

  logic [3:0]       fila_m, fila_s, fila_prev;
  logic [3:0]       col_m, col_s;
  logic [CNT_W-1:0] settle_cnt;
  logic [3:0]       rows_seen;
  logic [1:0]       key_cnt;
  logic [3:0]       key_code;

  logic             fila_cambio, fila_valida, muestra, fin_trama, trama_ok;
  logic [1:0]       fila_idx, col_idx;
  logic [2:0]       col_ones, suma;
  logic             res_none, res_single, res_multi;

  estado_t          estado, estado_n;
  logic [3:0]       cand, cand_n;
  logic [FW-1:0]    cnt, cnt_n, cnt_inc;
  logic [3:0]       tecla_n;
  logic             valida_n, suelta_n, pres_n, multi_n;

  // Two-flop synchronizers for the row pattern and column lines, plus the
  // previous synchronized row pattern used for change detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fila_m    <= '0;
      fila_s    <= '0;
      fila_prev <= '0;
      col_m     <= '0;
      col_s     <= '0;
    end else begin
      fila_m    <= fila;
      fila_s    <= fila_m;
      fila_prev <= fila_s;
      col_m     <= columna;
      col_s     <= col_m;
    end
  end

  assign fila_cambio = (fila_s != fila_prev);

  // Settle counter: restarts on every row change and saturates at SETTLE, so
  // the value SETTLE-1 is seen exactly once per stable row pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (fila_cambio) begin
      settle_cnt <= '0;
    end else if (settle_cnt != CNT_W'(SETTLE)) begin
      settle_cnt <= settle_cnt + CNT_W'(1);
    end
  end

  // Row index from the one-hot pattern; 1111 and anything else is not a row.
  always_comb begin
    fila_valida = 1'b1;
    fila_idx    = 2'd0;
    case (fila_s)
      4'b1000: fila_idx = 2'd0;
      4'b0100: fila_idx = 2'd1;
      4'b0010: fila_idx = 2'd2;
      4'b0001: fila_idx = 2'd3;
      default: fila_valida = 1'b0;
    endcase
  end

  // Column index counts from col_s[3]; only meaningful when one bit is set.
  always_comb begin
    if (col_s[3])      col_idx = 2'd0;
    else if (col_s[2]) col_idx = 2'd1;
    else if (col_s[1]) col_idx = 2'd2;
    else               col_idx = 2'd3;
  end

  assign col_ones  = {2'b00, col_s[0]} + {2'b00, col_s[1]} + {2'b00, col_s[2]} + {2'b00, col_s[3]};
  assign suma      = {1'b0, key_cnt} + col_ones;
  assign muestra   = !fila_cambio && fila_valida && (settle_cnt == CNT_W'(SETTLE - 1));
  assign fin_trama = fila_cambio && (fila_s == 4'b1111);
  assign trama_ok  = fin_trama && (rows_seen == 4'b1111);

  // Frame accumulator: which rows were sampled, a saturating key count
  // (0, 1, 2 meaning two or more) and the code of the first key found.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_seen <= '0;
      key_cnt   <= '0;
      key_code  <= '0;
    end else if (fin_trama) begin
      rows_seen <= '0;
      key_cnt   <= '0;
      key_code  <= '0;
    end else if (muestra) begin
      rows_seen <= rows_seen | (4'b0001 << fila_idx);
      key_cnt   <= (suma >= 3'd2) ? 2'd2 : suma[1:0];
      if (key_cnt == 2'd0 && col_ones == 3'd1) begin
        key_code <= {fila_idx, col_idx};
      end
    end
  end

  assign res_none   = (key_cnt == 2'd0);
  assign res_single = (key_cnt == 2'd1);
  assign res_multi  = (key_cnt == 2'd2);
  assign cnt_inc    = cnt + FW'(1);

  // Debounce FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado       <= IDLE;
      cand         <= '0;
      cnt          <= '0;
      tecla        <= '0;
      tecla_valida <= 1'b0;
      tecla_suelta <= 1'b0;
      presionada   <= 1'b0;
      multi_tecla  <= 1'b0;
    end else begin
      estado       <= estado_n;
      cand         <= cand_n;
      cnt          <= cnt_n;
      tecla        <= tecla_n;
      tecla_valida <= valida_n;
      tecla_suelta <= suelta_n;
      presionada   <= pres_n;
      multi_tecla  <= multi_n;
    end
  end

  // Next-state logic. The FSM only moves on a complete frame; discarded frames
  // leave everything untouched, including multi_tecla.
  always_comb begin
    estado_n = estado;
    cand_n   = cand;
    cnt_n    = cnt;
    tecla_n  = tecla;
    valida_n = 1'b0;
    suelta_n = 1'b0;
    pres_n   = presionada;
    multi_n  = multi_tecla;
    if (trama_ok) begin
      multi_n = res_multi;
      case (estado)
        IDLE: begin
          if (res_single) begin
            if (DEB_FRAMES == 1) begin
              tecla_n  = key_code;
              valida_n = 1'b1;
              pres_n   = 1'b1;
              estado_n = HELD;
            end else begin
              cand_n   = key_code;
              cnt_n    = FW'(1);
              estado_n = DEB_PRESS;
            end
          end
        end
        DEB_PRESS: begin
          if (res_single) begin
            if (key_code == cand) begin
              if (cnt_inc == FW'(DEB_FRAMES)) begin
                tecla_n  = cand;
                valida_n = 1'b1;
                pres_n   = 1'b1;
                estado_n = HELD;
              end else begin
                cnt_n = cnt_inc;
              end
            end else begin
              cand_n = key_code;
              cnt_n  = FW'(1);
            end
          end else begin
            estado_n = IDLE;
          end
        end
        HELD: begin
          if (res_none) begin
            if (DEB_FRAMES == 1) begin
              suelta_n = 1'b1;
              pres_n   = 1'b0;
              estado_n = IDLE;
            end else begin
              cnt_n    = FW'(1);
              estado_n = DEB_REL;
            end
          end
        end
        DEB_REL: begin
          if (res_none) begin
            if (cnt_inc == FW'(DEB_FRAMES)) begin
              suelta_n = 1'b1;
              pres_n   = 1'b0;
              estado_n = IDLE;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            estado_n = HELD;
          end
        end
        default: estado_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lector_columnas_teclado.sv
// tb_lector_columnas_teclado
// Drives a keypad row scanner plus a pressed-key set into the reader and checks
// every cycle against a frame-level reference model: synchronizer delay as a
// short history queue, settling as a run length, frames as a list of keys
// seen, and debouncing as a streak of identical frame results.
module tb_lector_columnas_teclado;

  localparam int SETTLE = 4;
  localparam int DEB    = 3;
  localparam int CNT_W  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] fila = 4'b0000;
  logic [3:0] columna = 4'b0000;
  logic [3:0] tecla;
  logic       tecla_valida, tecla_suelta, presionada, multi_tecla;

  always #5 clk = ~clk;

  lector_columnas_teclado #(.SETTLE(SETTLE), .DEB_FRAMES(DEB), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fila(fila), .columna(columna),
    .tecla(tecla), .tecla_valida(tecla_valida), .tecla_suelta(tecla_suelta),
    .presionada(presionada), .multi_tecla(multi_tecla)
  );

  int checks = 0;
  int passes = 0;
  int valid_seen = 0;
  int suelta_seen = 0;

  // Reference model state
  logic [3:0] fh[$];
  logic [3:0] ch[$];
  int         runlen = 1;
  int         frame_keys[$];
  logic [3:0] seen = 4'b0000;
  int         streak_kind = -1;
  int         streak_code = -1;
  int         streak_len = 0;
  logic [3:0] exp_tecla = 4'h0;
  logic       exp_valid = 1'b0, exp_suelta = 1'b0, exp_pres = 1'b0, exp_multi = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
  endtask

  function automatic int rowOf(input logic [3:0] f);
    for (int b = 0; b < 4; b++) if (f[3-b]) return b;
    return 0;
  endfunction

  // Column lines a real keypad shows for a given driven row set and key set.
  function automatic logic [3:0] colsFor(input logic [3:0] f, input logic [15:0] keys);
    logic [3:0] c;
    c = 4'b0000;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (f[3-r] && keys[4*r+k]) c[3-k] = 1'b1;
    return c;
  endfunction

  task automatic modelReset();
    fh.delete(); ch.delete();
    repeat (3) begin fh.push_back(4'h0); ch.push_back(4'h0); end
    runlen = 1; frame_keys.delete(); seen = 4'b0000;
    streak_kind = -1; streak_code = -1; streak_len = 0;
    exp_tecla = 4'h0; exp_valid = 0; exp_suelta = 0; exp_pres = 0; exp_multi = 0;
  endtask

  task automatic modelStep();
    logic [3:0] fs_now, fs_old, cs;
    int kind, code;
    fs_now = fh[1]; fs_old = fh[2]; cs = ch[1];
    exp_valid = 0; exp_suelta = 0;
    if (fs_now != fs_old) begin
      runlen = 1;
      if (fs_now == 4'b1111) begin
        if (seen == 4'b1111) begin
          code = -1;
          if (frame_keys.size() == 0) kind = 0;
          else if (frame_keys.size() == 1) begin kind = 1; code = frame_keys[0]; end
          else kind = 2;
          if (kind == streak_kind && code == streak_code) streak_len++;
          else begin streak_kind = kind; streak_code = code; streak_len = 1; end
          if (!exp_pres && kind == 1 && streak_len >= DEB) begin
            exp_tecla = 4'(code); exp_valid = 1; exp_pres = 1;
          end else if (exp_pres && kind == 0 && streak_len >= DEB) begin
            exp_suelta = 1; exp_pres = 0;
          end
          exp_multi = (kind == 2);
        end
        seen = 4'b0000;
        frame_keys.delete();
      end
    end else if (runlen < 100000) begin
      runlen++;
    end
    if (fs_now == fs_old && runlen == SETTLE + 1 && $countones(fs_now) == 1) begin
      int r;
      r = rowOf(fs_now);
      seen[r] = 1'b1;
      for (int k = 0; k < 4; k++) if (cs[3-k]) frame_keys.push_back(4*r + k);
    end
    fh.push_front(fila); void'(fh.pop_back());
    ch.push_front(columna); void'(ch.pop_back());
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) modelReset();
    else modelStep();
  end

  // Per-cycle comparison against the model, plus pulse counters.
  always @(negedge clk) begin
    checkOutput("cycle", int'({tecla, tecla_valida, tecla_suelta, presionada, multi_tecla}),
                int'({exp_tecla, exp_valid, exp_suelta, exp_pres, exp_multi}));
    if (!rst) begin
      if (tecla_valida) valid_seen++;
      if (tecla_suelta) suelta_seen++;
    end
  end

  // One scanner step: row pattern now, columns follow col_delay clocks later.
  task automatic driveStep(input logic [3:0] f, input logic [15:0] keys, input int len, input int col_delay);
    fila = f;
    for (int i = 0; i < len; i++) begin
      if (i == col_delay) columna = colsFor(f, keys);
      @(negedge clk);
    end
  endtask

  // One frame: four rows then 1111 (which closes the frame). glitch_row >= 0
  // replaces that row with a non-one-hot pattern.
  task automatic driveFrame(input logic [15:0] keys, input int step, input int col_delay, input int glitch_row);
    logic [3:0] pat;
    for (int r = 0; r < 4; r++) begin
      pat = 4'b1000 >> r;
      if (r == glitch_row) pat = 4'b1010;
      driveStep(pat, keys, step, col_delay);
    end
    driveStep(4'b1111, keys, step, col_delay);
  endtask

  task automatic applyStimulus(input logic [15:0] keys, input int frames, input int step, input int col_delay);
    repeat (frames) driveFrame(keys, step, col_delay, -1);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] keys;
    int hold, pick, step, cd, glitch, nfr, b1, b2;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", int'({tecla, tecla_valida, tecla_suelta, presionada, multi_tecla}), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] clean press of key 9");
    valid_seen = 0;
    applyStimulus(16'h0200, 3, 64, 0);
    checkOutput("press9_valid_count", valid_seen, 1);
    checkOutput("press9_tecla", tecla, 9);
    checkOutput("press9_model_tecla", exp_tecla, 9);
    checkOutput("press9_presionada", presionada, 1);
    applyStimulus(16'h0200, 1, 64, 0);
    checkOutput("press9_no_repeat", valid_seen, 1);

    $display("[TB] release of key 9");
    suelta_seen = 0;
    applyStimulus(16'h0000, 3, 64, 0);
    checkOutput("release_suelta_count", suelta_seen, 1);
    checkOutput("release_presionada", presionada, 0);
    checkOutput("release_tecla_held", tecla, 9);

    $display("[TB] bounce on key 9");
    valid_seen = 0;
    applyStimulus(16'h0200, 2, 64, 0);
    applyStimulus(16'h0000, 1, 64, 0);
    applyStimulus(16'h0200, 2, 64, 0);
    checkOutput("bounce_none_yet", valid_seen, 0);
    applyStimulus(16'h0200, 1, 64, 0);
    checkOutput("bounce_valid_count", valid_seen, 1);
    applyStimulus(16'h0000, 3, 64, 0);

    $display("[TB] two keys then key 0");
    valid_seen = 0;
    applyStimulus(16'h1001, 3, 64, 0);
    checkOutput("multi_level", multi_tecla, 1);
    checkOutput("multi_model_level", exp_multi, 1);
    checkOutput("multi_no_valid", valid_seen, 0);
    applyStimulus(16'h0001, 3, 64, 0);
    checkOutput("key0_valid_count", valid_seen, 1);
    checkOutput("key0_tecla", tecla, 0);
    checkOutput("key0_multi_clear", multi_tecla, 0);
    applyStimulus(16'h0000, 3, 64, 0);

    $display("[TB] late column change within settle window");
    applyStimulus(16'h0040, 3, 64, 4);
    checkOutput("settle_tecla", tecla, 6);
    checkOutput("settle_presionada", presionada, 1);
    applyStimulus(16'h0000, 3, 64, 4);

    $display("[TB] asynchronous reset mid-frame");
    applyStimulus(16'h0020, 3, 64, 0);
    checkOutput("pre_reset_presionada", presionada, 1);
    driveStep(4'b1000, 16'h0020, 64, 0);
    fila = 4'b0100;
    columna = colsFor(4'b0100, 16'h0020);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset_outputs", int'({tecla, tecla_valida, tecla_suelta, presionada, multi_tecla}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    driveStep(4'b0010, 16'h0020, 64, 0);
    driveStep(4'b0001, 16'h0020, 64, 0);
    driveStep(4'b1111, 16'h0020, 64, 0);
    valid_seen = 0;
    applyStimulus(16'h0020, 2, 64, 0);
    checkOutput("after_reset_discard", valid_seen, 0);
    applyStimulus(16'h0020, 1, 64, 0);
    checkOutput("after_reset_valid", valid_seen, 1);
    checkOutput("after_reset_tecla", tecla, 5);
    applyStimulus(16'h0000, 3, 64, 0);

    $display("[TB] randomized frames");
    nfr = 0;
    while (nfr < 70) begin
      hold = $urandom_range(1, 5);
      pick = $urandom_range(0, 99);
      b1 = $urandom_range(0, 15);
      b2 = (b1 + $urandom_range(1, 15)) % 16;
      if (pick < 40) keys = 16'h0000;
      else if (pick < 85) keys = 16'(1) << b1;
      else keys = (16'(1) << b1) | (16'(1) << b2);
      step = $urandom_range(5, 24);
      cd = $urandom_range(0, 3);
      repeat (hold) begin
        glitch = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1;
        driveFrame(keys, step, cd, glitch);
        nfr++;
      end
    end
    applyStimulus(16'h0000, 3, 20, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
